// File: rtl/ram_bist_if.sv
// Two-port RAM test bus: BIST master drives both ports, RAM slave returns
// read data and the same-address dual-write conflict flag.
interface ram_bist_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 3
);
    logic              en_a;
    logic              wr_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              en_b;
    logic              wr_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              conflict;

    modport master (
        output en_a, wr_a, addr_a, wdata_a,
        output en_b, wr_b, addr_b, wdata_b,
        input  rdata_a, rdata_b, conflict
    );

    modport slave (
        input  en_a, wr_a, addr_a, wdata_a,
        input  en_b, wr_b, addr_b, wdata_b,
        output rdata_a, rdata_b, conflict
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// March BIST controller for the two-port RAM: write P via A, read/compare
// via B, write ~P via B, read/compare via A, then report pass/fail.
// Optional build macro CONFLICT_CHK_EN inserts a one-cycle dual-write state
// between the write and read phases that checks the RAM conflict flag.
module ram_bist_ctrl #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    ram_bist_if.master        ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W+1:0] err_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned ERR_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WRI  = 3'd4;
    localparam logic [2:0] S_RDI  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;
`ifdef CONFLICT_CHK_EN
    localparam logic [2:0] S_CF   = 3'd2;
    localparam logic [2:0] S_POST_WR = S_CF;
`else
    localparam logic [2:0] S_POST_WR = S_RD;
`endif

    // Pattern word for an address: address folded to data width, XOR seed.
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] s);
        return DATA_W'(a) ^ s;
    endfunction

    logic [2:0]        state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              busy_d, done_d, pass_d;
    logic [ADDR_W-1:0] fail_d;
    logic [ERR_W-1:0]  err_d;

    // Compare pipeline: one read in flight, checked the cycle after issue.
    logic              cmp_valid, cmp_valid_d;
    logic              cmp_port, cmp_port_d;
    logic [DATA_W-1:0] cmp_exp, cmp_exp_d;
    logic [ADDR_W-1:0] cmp_addr, cmp_addr_d;

    logic              err_hit;
    logic [ADDR_W-1:0] err_at;
    logic [DATA_W-1:0] rd_sel;

    logic              en_a_d, wr_a_d, en_b_d, wr_b_d;
    logic [ADDR_W-1:0] addr_a_d, addr_b_d;
    logic [DATA_W-1:0] wdata_a_d, wdata_b_d;

`ifndef CONFLICT_CHK_EN
    logic unused_conflict;
    assign unused_conflict = ram.conflict;
`endif

    // Next state, datapath updates and next-cycle RAM port drive.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        seed_d      = seed_q;
        busy_d      = busy;
        done_d      = 1'b0;
        pass_d      = pass;
        fail_d      = fail_addr;
        err_d       = err_cnt;
        cmp_valid_d = 1'b0;
        cmp_port_d  = 1'b0;
        cmp_exp_d   = '0;
        cmp_addr_d  = '0;
        err_hit     = 1'b0;
        err_at      = '0;
        rd_sel      = cmp_port ? ram.rdata_b : ram.rdata_a;
        en_a_d      = 1'b0;
        wr_a_d      = 1'b0;
        addr_a_d    = '0;
        wdata_a_d   = '0;
        en_b_d      = 1'b0;
        wr_b_d      = 1'b0;
        addr_b_d    = '0;
        wdata_b_d   = '0;

        if (cmp_valid && (rd_sel != cmp_exp)) begin
            err_hit = 1'b1;
            err_at  = cmp_addr;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR;
                    cnt_d   = '0;
                    seed_d  = seed;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = '0;
                    err_d   = '0;
                end
            end
            S_WR: begin
                cnt_d = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) state_d = S_POST_WR;
            end
`ifdef CONFLICT_CHK_EN
            S_CF: begin
                state_d = S_RD;
                cnt_d   = '0;
                if (!ram.conflict) begin
                    err_hit = 1'b1;
                    err_at  = '0;
                end
            end
`endif
            S_RD: begin
                cnt_d       = cnt + ADDR_W'(1);
                cmp_valid_d = 1'b1;
                cmp_port_d  = 1'b1;
                cmp_exp_d   = pat(cnt, seed_q);
                cmp_addr_d  = cnt;
                if (cnt == LAST_ADDR) state_d = S_WRI;
            end
            S_WRI: begin
                cnt_d = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) state_d = S_RDI;
            end
            S_RDI: begin
                cnt_d       = cnt + ADDR_W'(1);
                cmp_valid_d = 1'b1;
                cmp_port_d  = 1'b0;
                cmp_exp_d   = ~pat(cnt, seed_q);
                cmp_addr_d  = cnt;
                if (cnt == LAST_ADDR) state_d = S_FIN;
            end
            S_FIN: begin
                // Wait for the last in-flight compare before reporting.
                if (!cmp_valid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt == '0);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (err_hit) begin
            if (err_cnt != {ERR_W{1'b1}}) err_d = err_cnt + ERR_W'(1);
            if (err_cnt == '0) fail_d = err_at;
        end

        case (state_d)
            S_WR: begin
                en_a_d    = 1'b1;
                wr_a_d    = 1'b1;
                addr_a_d  = cnt_d;
                wdata_a_d = pat(cnt_d, seed_d);
            end
`ifdef CONFLICT_CHK_EN
            S_CF: begin
                en_a_d    = 1'b1;
                wr_a_d    = 1'b1;
                addr_a_d  = '0;
                wdata_a_d = ~pat('0, seed_d);
                en_b_d    = 1'b1;
                wr_b_d    = 1'b1;
                addr_b_d  = '0;
                wdata_b_d = ~pat('0, seed_d) ^ DATA_W'(1);
            end
`endif
            S_RD: begin
                en_b_d   = 1'b1;
                addr_b_d = cnt_d;
            end
            S_WRI: begin
                en_b_d    = 1'b1;
                wr_b_d    = 1'b1;
                addr_b_d  = cnt_d;
                wdata_b_d = ~pat(cnt_d, seed_d);
            end
            S_RDI: begin
                en_a_d   = 1'b1;
                addr_a_d = cnt_d;
            end
            default: begin
                en_a_d = 1'b0;
            end
        endcase
    end

    // State, compare pipeline and registered outputs; reset aborts any test.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            seed_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            err_cnt     <= '0;
            cmp_valid   <= 1'b0;
            cmp_port    <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            ram.en_a    <= 1'b0;
            ram.wr_a    <= 1'b0;
            ram.addr_a  <= '0;
            ram.wdata_a <= '0;
            ram.en_b    <= 1'b0;
            ram.wr_b    <= 1'b0;
            ram.addr_b  <= '0;
            ram.wdata_b <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            seed_q      <= seed_d;
            busy        <= busy_d;
            done        <= done_d;
            pass        <= pass_d;
            fail_addr   <= fail_d;
            err_cnt     <= err_d;
            cmp_valid   <= cmp_valid_d;
            cmp_port    <= cmp_port_d;
            cmp_exp     <= cmp_exp_d;
            cmp_addr    <= cmp_addr_d;
            ram.en_a    <= en_a_d;
            ram.wr_a    <= wr_a_d;
            ram.addr_a  <= addr_a_d;
            ram.wdata_a <= wdata_a_d;
            ram.en_b    <= en_b_d;
            ram.wr_b    <= wr_b_d;
            ram.addr_b  <= addr_b_d;
            ram.wdata_b <= wdata_b_d;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: behavioural two-port RAM with injectable faults,
// table-driven runs, randomized runs against a march reference model, and
// hand sequences for mid-test reset and ignored restart.
module tb_ram_bist_ctrl;

`ifdef CONFLICT_CHK_EN
    localparam int LAT = 35;
`else
    localparam int LAT = 34;
`endif

    bit          clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  seed_in;
    logic        busy, done, pass;
    logic [2:0]  fail_addr;
    logic [4:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    int fault_mode;   // 0 good, 1 bit0 stuck-0, 2 B-read corrupt, 3 A-read corrupt, 4 bit1 stuck-1
    int fault_addr;
    bit cf_tied;      // RAM conflict output tied 0, last writer wins

    logic       f_busy, f_en_a, f_wr_a, f_en_b;
    logic [2:0] f_addr_a, f_wdata_a;
    logic       busy_at_done;

    ram_bist_if #(.ADDR_W(3), .DATA_W(3)) bif ();

    ram_bist_ctrl #(.ADDR_W(3), .DATA_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed_in),
        .ram       (bif),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAM
    logic [2:0] mem [8];

    function automatic logic [2:0] store(input logic [2:0] v);
        if (fault_mode == 1) return v & 3'b110;
        if (fault_mode == 4) return v | 3'b010;
        return v;
    endfunction

    assign bif.conflict = bif.en_a && bif.wr_a && bif.en_b && bif.wr_b &&
                          (bif.addr_a == bif.addr_b) && !cf_tied;

    always @(posedge clk) begin
        if (bif.en_a && !bif.wr_a)
            bif.rdata_a <= mem[bif.addr_a] ^
                ((fault_mode == 3 && int'(bif.addr_a) == fault_addr) ? 3'd1 : 3'd0);
        if (bif.en_b && !bif.wr_b)
            bif.rdata_b <= mem[bif.addr_b] ^
                ((fault_mode == 2 && int'(bif.addr_b) == fault_addr) ? 3'd1 : 3'd0);
        if (!bif.conflict) begin
            if (bif.en_a && bif.wr_a) mem[bif.addr_a] <= store(bif.wdata_a);
            if (bif.en_b && bif.wr_b) mem[bif.addr_b] <= store(bif.wdata_b);
        end
    end

`ifndef CONFLICT_CHK_EN
    int dual_cnt = 0;
    always @(posedge clk)
        if (bif.en_a && bif.wr_a && bif.en_b && bif.wr_b && bif.addr_a == bif.addr_b)
            dual_cnt++;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // March reference model: whole test computed on an array
    function automatic void note(input int a, inout int err, inout int fail);
        if (err == 0) fail = a;
        if (err < 31) err++;
    endfunction

    function automatic int mstore(input int v, input int mode);
        if (mode == 1) return v & 6;
        if (mode == 4) return v | 2;
        return v;
    endfunction

    function automatic void model(input int s, input int mode, input int fa,
                                  output int err, output int fail);
        int m [8];
        int r;
        err = 0;
        fail = 0;
        for (int a = 0; a < 8; a++) m[a] = mstore(a ^ s, mode);
`ifdef CONFLICT_CHK_EN
        if (cf_tied) begin
            note(0, err, fail);
            m[0] = mstore(((~s) & 7) ^ 1, mode);
        end
`endif
        for (int a = 0; a < 8; a++) begin
            r = m[a] ^ ((mode == 2 && a == fa) ? 1 : 0);
            if (r != (a ^ s)) note(a, err, fail);
        end
        for (int a = 0; a < 8; a++) m[a] = mstore((~(a ^ s)) & 7, mode);
        for (int a = 0; a < 8; a++) begin
            r = m[a] ^ ((mode == 3 && a == fa) ? 1 : 0);
            if (r != ((~(a ^ s)) & 7)) note(a, err, fail);
        end
    endfunction

    // Start a test and watch 60 cycles; optional second start at again_at.
    task automatic run_one(input logic [2:0] s, input int again_at,
                           output int lat, output int ndone);
        lat = -1;
        ndone = 0;
        seed_in = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        f_busy = busy; f_en_a = bif.en_a; f_wr_a = bif.wr_a; f_en_b = bif.en_b;
        f_addr_a = bif.addr_a; f_wdata_a = bif.wdata_a;
        busy_at_done = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            start = (c == again_at);
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    busy_at_done = busy;
                end
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [2:0] seed;
        int mode;
        int faddr;
        int exp_pass;
        int exp_err;
        int exp_fail;
    } vec_t;

    vec_t tv [5];

    initial begin
        int lat, nd, me, mf, nseen;

        tv[0] = '{3'd5, 0, 0, 1, 0, 0};
        tv[1] = '{3'd5, 1, 0, 0, 8, 0};
        tv[2] = '{3'd0, 2, 6, 0, 1, 6};
        tv[3] = '{3'd3, 3, 2, 0, 1, 2};
        tv[4] = '{3'd0, 4, 0, 0, 8, 0};

        rst_n = 1'b1; start = 1'b0; seed_in = '0;
        fault_mode = 0; fault_addr = 0; cf_tied = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ports", int'({bif.en_a, bif.wr_a, bif.en_b, bif.wr_b}), 0);
        chk("rst_addr", int'({bif.addr_a, bif.addr_b}), 0);
        chk("rst_wdata", int'({bif.wdata_a, bif.wdata_b}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_fail_addr", int'(fail_addr), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // First write cycle follows the accepted start immediately
        run_one(3'd6, -1, lat, nd);
        chk("first_busy", int'(f_busy), 1);
        chk("first_en_a", int'(f_en_a), 1);
        chk("first_wr_a", int'(f_wr_a), 1);
        chk("first_en_b", int'(f_en_b), 0);
        chk("first_addr_a", int'(f_addr_a), 0);
        chk("first_wdata_a", int'(f_wdata_a), 6);

        // Table-driven fault scenarios
        foreach (tv[i]) begin
            fault_mode = tv[i].mode;
            fault_addr = tv[i].faddr;
            run_one(tv[i].seed, -1, lat, nd);
            chk($sformatf("tv%0d_latency", i), lat, LAT);
            chk($sformatf("tv%0d_done_count", i), nd, 1);
            chk($sformatf("tv%0d_busy_at_done", i), int'(busy_at_done), 0);
            chk($sformatf("tv%0d_pass", i), int'(pass), tv[i].exp_pass);
            chk($sformatf("tv%0d_err_cnt", i), int'(err_cnt), tv[i].exp_err);
            chk($sformatf("tv%0d_fail_addr", i), int'(fail_addr), tv[i].exp_fail);
        end

        // Randomized runs against the reference model
        for (int k = 0; k < 12; k++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            fault_mode = int'($urandom_range(0, 4));
            fault_addr = int'($urandom_range(0, 7));
            model(int'(s), fault_mode, fault_addr, me, mf);
            run_one(s, -1, lat, nd);
            chk($sformatf("rnd%0d_latency", k), lat, LAT);
            chk($sformatf("rnd%0d_err_cnt", k), int'(err_cnt), me);
            chk($sformatf("rnd%0d_fail_addr", k), int'(fail_addr), mf);
            chk($sformatf("rnd%0d_pass", k), int'(pass), (me == 0) ? 1 : 0);
        end
        fault_mode = 0;

        // Second start during a test is ignored
        run_one(3'd5, 5, lat, nd);
        chk("restart_done_count", nd, 1);
        chk("restart_latency", lat, LAT);
        chk("restart_pass", int'(pass), 1);

        // Reset during RD aborts the test
        seed_in = 3'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid_busy_before", int'(busy), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk("mid_rst_ports", int'({bif.en_a, bif.wr_a, bif.en_b, bif.wr_b}), 0);
        chk("mid_rst_addr", int'({bif.addr_a, bif.addr_b}), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pass", int'(pass), 0);
        chk("mid_rst_err", int'(err_cnt), 0);
        nseen = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done) nseen++;
        end
        chk("mid_rst_no_done", nseen, 0);
        run_one(3'd5, -1, lat, nd);
        chk("post_rst_latency", lat, LAT);
        chk("post_rst_pass", int'(pass), 1);

`ifdef CONFLICT_CHK_EN
        // Conflict flag tied low with last-writer-wins RAM
        cf_tied = 1'b1;
        model(5, 0, 0, me, mf);
        run_one(3'd5, -1, lat, nd);
        chk("cf_latency", lat, LAT);
        chk("cf_err_ge2", (int'(err_cnt) >= 2) ? 1 : 0, 1);
        chk("cf_err_model", int'(err_cnt), me);
        chk("cf_fail_addr", int'(fail_addr), 0);
        chk("cf_pass", int'(pass), 0);
        cf_tied = 1'b0;
`else
        chk("no_dual_write", dual_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Initiator/test master for the team's two-port RAM; drives both RAM ports (en/addr/wdata/wr) and consumes rdata/conflict.
- Runs a four-phase march: write pattern via A, read/compare via B, write inverse via B, read/compare via A.
- Reports pass/fail, first failing address and error count.
- Sits between the RAM and the board-level start/status logic.

Parameters:
ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W words tested
DATA_W, 3, RAM data width

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  synchronous reset, active-high (reset asserted while rst_n=1)
start  in  1  one-cycle request; sampled only in IDLE
seed  in  DATA_W  pattern seed, latched on accepted start
en_a  out  1  RAM port A enable
wr_a  out  1  RAM port A write (1) / read (0)
addr_a  out  ADDR_W  RAM port A address
wdata_a  out  DATA_W  RAM port A write data
en_b  out  1  RAM port B enable
wr_b  out  1  RAM port B write/read
addr_b  out  ADDR_W  RAM port B address
wdata_b  out  DATA_W  RAM port B write data
rdata_a  in  DATA_W  RAM port A read data, valid 1 cycle after read issue
rdata_b  in  DATA_W  RAM port B read data, valid 1 cycle after read issue
conflict  in  1  RAM same-address dual-write flag (combinational from RAM)
busy  out  1  test in progress
done  out  1  one-cycle pulse at end of test
pass  out  1  held result of last test; 1 = zero errors
fail_addr  out  ADDR_W  address of first mismatch of last test
err_cnt  out  ADDR_W+2  mismatch count of last test, saturating at all-ones

Behaviour:
- Reset (rst_n=1 at posedge): state IDLE, all outputs 0 (en_a/en_b/wr_a/wr_b/addr/wdata/busy/done/pass/fail_addr/err_cnt). Reset mid-test aborts: enables drop at that same edge, no done pulse.
- Pattern: P(a) = a[DATA_W-1:0] XOR seed_q (address zero-extended or truncated to DATA_W); inverse = ~P(a).
- FSM: IDLE -> WR -> RD -> WRI -> RDI -> FIN -> IDLE.
- IDLE: start=1 latches seed, clears err_cnt/fail_addr/pass, busy=1 from next cycle. start while busy is ignored.
- WR: DEPTH cycles; en_a=1, wr_a=1, addr_a=0..DEPTH-1, wdata_a=P(addr); port B idle (en_b=0).
- RD: DEPTH cycles; en_b=1, wr_b=0, addr_b=0..DEPTH-1; port A idle.
- WRI: DEPTH cycles; en_b=1, wr_b=1, addr_b=0..DEPTH-1, wdata_b=~P(addr).
- RDI: DEPTH cycles; en_a=1, wr_a=0, addr_a=0..DEPTH-1.
- Compare pipeline: each issued read registers expected value, address and a valid flag. The compare happens the following cycle against the issuing port's rdata. The RD->WRI and RDI->FIN transitions occur while the last compare is in flight; the compare still completes.
- Mismatch: err_cnt increments, saturating. On the first mismatch only, fail_addr is captured.
- FIN: one cycle, after the final RDI compare; done=1, pass=(err_cnt==0), busy=0 at next edge.
- Latency: start edge to done = 4*DEPTH+2 cycles (34 for DEPTH=8).
- Address counter wraps DEPTH-1 -> 0 at each phase boundary.
- Never drives en_a&wr_a and en_b&wr_b to the same address, except in the optional phase below.

Optional Feature:
CONFLICT_CHK_EN
- Defined: an extra one-cycle state CF between WR and RD. It drives en_a=en_b=1, wr_a=wr_b=1, addr_a=addr_b=0, wdata_a=~P(0), wdata_b=~P(0)^1.
- In CF, conflict must read 1; otherwise err_cnt increments and fail_addr captures 0 if it is the first error.
- The RD phase then checks that address 0 still holds P(0).
- Latency becomes 4*DEPTH+3.
- Not defined: CF absent, conflict input ignored, latency 4*DEPTH+2.

Test Plan:
- Good RAM model, seed=3'b101, start pulse -> done exactly 34 cycles later, pass=1, err_cnt=0, fail_addr=0.
- RAM model with data bit0 stuck at 0, seed=3'b101 -> pass=0, err_cnt=8 (4 in RD, 4 in RDI), fail_addr=0.
- RAM model corrupting only address 6 on port B reads, seed=0 -> err_cnt=1, fail_addr=6, pass=0.
- rst_n=1 for one cycle during RD (cycle 12 after start) -> next edge all outputs 0, no done; new start then completes normally with pass=1.
- start pulsed again at cycle 5 of a test -> ignored, single done at cycle 34, no restart.
- With CONFLICT_CHK_EN, good RAM -> done at cycle 35, pass=1. Same test with RAM conflict output tied 0 and last-writer-wins -> err_cnt>=2, fail_addr=0.
